// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator: the FSM state encoding and
// the default widths matching the upstream 4x4 multiplier.
package product_acc_pkg;

    // Width of one incoming product (4x4 unsigned multiply gives 8 bits)
    localparam int DEFAULT_PROD_W = 8;

    // Default accumulator width; 16 maximal products (16*225=3600) fit in 12 bits
    localparam int DEFAULT_ACC_W = 12;

    // Width of the remaining-products counter; must hold the value 16
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Accumulates a run of unsigned products into a modulo-2^ACC_W sum with a
// sticky carry-out flag. A run is started in IDLE with a length (0 means 16),
// consumes that many products through a valid/ready handshake and then holds
// the result until the consumer takes it. abort cancels a run at any time.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEFAULT_PROD_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    input  logic              out_ready,
    output logic              busy
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] remaining;

    // One extra bit above the accumulator catches the carry of each addition
    logic [ACC_W:0]   sum;

    // Next accumulator value for a transfer, with carry in the top bit
    always_comb begin
        sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    end

    // FSM, accumulator, overflow flag and run counter; rst beats abort, which
    // beats start and any transfer in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= (len == 4'd0) ? CNT_W'(16) : {1'b0, len};
                        acc       <= '0;
                        ovf       <= 1'b0;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc       <= sum[ACC_W-1:0];
                        if (sum[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode straight from the state register
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_acc   = acc;
        out_ovf   = ovf;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. Two instances share the stimulus:
// one with the default 12-bit accumulator and one with a 9-bit accumulator
// to exercise the overflow flag.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = 4'd0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_prod = 8'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [11:0] out_acc;
    logic        in_ready9, out_valid9, out_ovf9, busy9;
    logic [8:0]  out_acc9;

    int passed = 0;
    int total  = 0;

    product_accumulator #(.PROD_W(8), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready),
        .out_valid(out_valid), .out_acc(out_acc), .out_ovf(out_ovf),
        .out_ready(out_ready), .busy(busy)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready9),
        .out_valid(out_valid9), .out_acc(out_acc9), .out_ovf(out_ovf9),
        .out_ready(out_ready), .busy(busy9)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [3:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] p);
        in_valid = 1'b1;
        in_prod  = p;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000) $display("[TB] FAIL reset_flags got %b want 0000", {in_ready, out_valid, busy, out_ovf});
        else passed++;
        total++;
        if (out_acc !== 12'd0) $display("[TB] FAIL reset_acc got %0d want 0", out_acc);
        else passed++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        begin_run(4'd3);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL basic_accstate got ready=%b busy=%b want 1 1", in_ready, busy);
        else passed++;
        send(8'd15);
        send(8'd225);
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL basic_early_valid got %b want 0", out_valid);
        else passed++;
        send(8'd1);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_acc !== 12'd241 || out_ovf !== 1'b0) $display("[TB] FAIL basic_result got v=%b acc=%0d ovf=%b want 1 241 0", out_valid, out_acc, out_ovf);
        else passed++;
        step();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL basic_return got v=%b busy=%b want 0 0", out_valid, busy);
        else passed++;
    endtask

    task automatic test_len16();
        out_ready = 1'b0;
        begin_run(4'd0);
        for (int i = 0; i < 15; i++) send(8'd225);
        total++;
        if (out_valid !== 1'b0 || out_acc !== 12'd3375) $display("[TB] FAIL len16_after15 got v=%b acc=%0d want 0 3375", out_valid, out_acc);
        else passed++;
        send(8'd225);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_acc !== 12'd3600 || out_ovf !== 1'b0) $display("[TB] FAIL len16_result got v=%b acc=%0d ovf=%b want 1 3600 0", out_valid, out_acc, out_ovf);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        begin_run(4'd3);
        send(8'd200);
        send(8'd200);
        total++;
        if (out_ovf9 !== 1'b0 || out_acc9 !== 9'd400) $display("[TB] FAIL ovf_partial got acc=%0d ovf=%b want 400 0", out_acc9, out_ovf9);
        else passed++;
        send(8'd200);
        in_valid = 1'b0;
        total++;
        if (out_valid9 !== 1'b1 || out_acc9 !== 9'd88 || out_ovf9 !== 1'b1) $display("[TB] FAIL ovf_acc9 got v=%b acc=%0d ovf=%b want 1 88 1", out_valid9, out_acc9, out_ovf9);
        else passed++;
        total++;
        if (out_acc !== 12'd600 || out_ovf !== 1'b0) $display("[TB] FAIL ovf_acc12 got acc=%0d ovf=%b want 600 0", out_acc, out_ovf);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_gaps_hold();
        out_ready = 1'b0;
        begin_run(4'd2);
        send(8'd10);
        in_valid = 1'b0;
        in_prod  = 8'd77;
        for (int i = 0; i < 3; i++) step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 12'd10) $display("[TB] FAIL gap_hold got rdy=%b v=%b acc=%0d want 1 0 10", in_ready, out_valid, out_acc);
        else passed++;
        send(8'd20);
        in_prod = 8'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_acc !== 12'd30 || in_ready !== 1'b0) $display("[TB] FAIL done_hold%0d got v=%b acc=%0d rdy=%b want 1 30 0", i, out_valid, out_acc, in_ready);
            else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 4'd1;
        step();
        start     = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) $display("[TB] FAIL handshake_start got busy=%b v=%b want 0 0", busy, out_valid);
        else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        out_ready = 1'b0;
        begin_run(4'd4);
        send(8'd5);
        send(8'd6);
        abort    = 1'b1;
        in_prod  = 8'd50;
        start    = 1'b1;
        step();
        abort    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_acc !== 12'd11) $display("[TB] FAIL abort_idle got busy=%b rdy=%b v=%b acc=%0d want 0 0 0 11", busy, in_ready, out_valid, out_acc);
        else passed++;
        begin_run(4'd1);
        send(8'd7);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_acc !== 12'd7 || out_ovf !== 1'b0) $display("[TB] FAIL abort_rerun got v=%b acc=%0d ovf=%b want 1 7 0", out_valid, out_acc, out_ovf);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b0;
        begin_run(4'd3);
        send(8'd4);
        rst     = 1'b1;
        start   = 1'b1;
        abort   = 1'b1;
        in_prod = 8'd9;
        step();
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000 || out_acc !== 12'd0) $display("[TB] FAIL midrun_reset got flags=%b acc=%0d want 0000 0", {in_ready, out_valid, busy, out_ovf}, out_acc);
        else passed++;
        begin_run(4'd2);
        send(8'd3);
        send(8'd4);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_acc !== 12'd7) $display("[TB] FAIL post_reset_run got v=%b acc=%0d want 1 7", out_valid, out_acc);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len16();
        test_overflow();
        test_gaps_hold();
        test_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter PROD_W, default 8, meaning the width of each incoming product (the upstream 4x4 multiplier output).
REQ-002 The block SHALL have parameter ACC_W, default 12, meaning the accumulator width (must be at least PROD_W).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning begin a new accumulation run; sampled only in IDLE.
REQ-006 The block SHALL have port len, input, 4, meaning the number of products in the run, latched at start; 0 encodes 16.
REQ-007 The block SHALL have port abort, input, 1, meaning a synchronous cancel of the current run.
REQ-008 The block SHALL have port in_valid, input, 1, meaning in_prod is valid.
REQ-009 The block SHALL have port in_prod, input, PROD_W, meaning the unsigned product.
REQ-010 The block SHALL have port in_ready, output, 1, meaning the block accepts in_prod this cycle.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-012 The block SHALL have port out_acc, output, ACC_W, meaning the accumulated sum.
REQ-013 The block SHALL have port out_ovf, output, 1, meaning at least one addition in the run carried out of ACC_W.
REQ-014 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-015 The block SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch len into the remaining counter (0 loads 16), clear the accumulator and ovf, and enter ACC on the next edge.
REQ-018 The block SHALL hold in_ready=1 only in ACC; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-019 On each transfer, acc SHALL become acc+in_prod modulo 2^ACC_W, ovf SHALL be set (sticky) if that sum carries out, and remaining SHALL decrement.
REQ-020 A transfer with remaining=1 SHALL move the FSM to DONE; out_valid SHALL be high in the very next cycle, with out_acc including that last product.
REQ-021 In ACC with in_valid=0, the block SHALL hold all state unchanged (no timeout).
REQ-022 In DONE, out_valid=1 and out_acc/out_ovf SHALL stay stable until out_ready=1, after which the FSM returns to IDLE on that edge.
REQ-023 start SHALL be ignored outside IDLE; start in the same cycle as the DONE-to-IDLE handshake SHALL NOT begin a run.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge, discard any concurrent transfer, and clear out_valid; abort has priority over start and transfers.
REQ-025 out_acc and out_ovf SHALL reflect the internal registers at all times; they are meaningful only while out_valid=1.

Reset
REQ-026 rst=1 SHALL, at the clock edge, force IDLE, acc=0, ovf=0 and remaining=0, and drive in_ready=0, out_valid=0 and busy=0; rst has priority over abort, start and all transfers, including mid-run.

Structure
REQ-027 The state enum (IDLE, ACC, DONE) and the default PROD_W/ACC_W constants SHALL reside in a shared package, product_acc_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the adder, counter and FSM are inline registers.

Verification
REQ-029 The bench SHALL drive start with len=3, then products 15, 225 and 1 back-to-back with out_ready=1 and check out_acc=241 and ovf=0, with out_valid exactly one cycle after the 3rd transfer.
REQ-030 The bench SHALL drive len=0, then 16 products of 225 and check out_acc=3600 and ovf=0 (ACC_W=12).
REQ-031 The bench SHALL set ACC_W=9 and len=3, drive 200, 200 and 200, and check out_acc=88 (600 mod 512) and ovf=1.
REQ-032 The bench SHALL insert in_valid gaps and hold out_ready=0 for 5 cycles, and check that out_acc is held stable and no extra products are accepted.
REQ-033 The bench SHALL assert abort after 2 of 4 products, then start a new run with len=1 and product 7, and check out_acc=7.
REQ-034 The bench SHALL assert rst mid-run and check all outputs are 0 and busy=0 on the next cycle, and that a subsequent start behaves normally.
